// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the RV32I core: fetches into the instruction register,
// walks DECODE/EXEC/MEM/WB by opcode, owns PC and instret, and traps on faults.
module mc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        br_taken,
  input  logic [31:0] tgt_addr,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_OPIMM  = 7'b001_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // The wait counter only ever needs to hold TIMEOUT-1 before the trap fires.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       instret_q, instret_d;
  logic              trap_q, trap_d;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              take_q, take_d;
  logic [31:0]       tgt_q, tgt_d;

  logic [6:0]  opcode;
  logic        is_load, is_store, is_branch, is_jump, is_legal;
  logic        take_now, timed_out;
  logic        retire, ret_take;
  logic [31:0] ret_tgt;

  assign opcode    = instr_q[6:0];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign is_legal  = is_load || is_store || is_branch || is_jump ||
                     (opcode == OPC_OP) || (opcode == OPC_OPIMM) ||
                     (opcode == OPC_LUI) || (opcode == OPC_AUIPC);

  assign take_now  = is_jump || (is_branch && br_taken);
  assign timed_out = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    wait_d    = '0;
    take_d    = take_q;
    tgt_d     = tgt_q;
    retire    = 1'b0;
    ret_take  = take_q;
    ret_tgt   = tgt_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        // Target is only valid here; keep it for a jump retiring out of WB.
        take_d = take_now;
        tgt_d  = tgt_addr;
        if (take_now && (tgt_addr[1:0] != 2'b00)) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_MISALIGN;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          retire   = 1'b1;
          ret_take = take_now;
          ret_tgt  = tgt_addr;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) retire = 1'b1;
          else          state_d = S_WB;
        end else if (timed_out) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (retire) begin
      pc_d      = ret_take ? ret_tgt : (pc_q + 32'd4);
      instret_d = instret_q + 32'd1;
      state_d   = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
    end
  end

  always_ff @(posedge clk) begin
    take_q <= take_d;
    tgt_q  <= tgt_d;
  end

  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule
